retire_trace_mon: RTL
=====================

RETIRE_TRACE_MON -- requirements
Module: retire_trace_mon

Interface
REQ-001: Parameter RET_W, default 2: number of retire lanes per cycle (1..4).
REQ-002: Parameter DEPTH, default 16: trace FIFO entries (power of two, at least 4).
REQ-003: Parameter CNT_W, default 32: width of each statistics counter.
REQ-004: clk  in  1  system clock; one clock domain; every state updates on the posedge.
REQ-005: rst  in  1  reset; asynchronous, active-high.
REQ-006: ret_vld_i  in  RET_W  per-lane retire valid.
REQ-007: ret_pc_i  in  RET_W x 64  per-lane retiring PC.
REQ-008: ret_wr_en_i  in  RET_W  per-lane flag: the instruction writes an architectural register (non-ZERO_REG destination).
REQ-009: ret_dest_i  in  RET_W x 5  per-lane logical destination.
REQ-010: ret_data_i  in  RET_W x 64  per-lane writeback value.
REQ-011: error_status_i  in  4  core error status; 4'h0 = NO_ERROR.
REQ-012: trace_rdy_i  in  1  consumer ready.
REQ-013: trace_vld_o / trace_pc_o / trace_wr_o / trace_dest_o / trace_data_o  out  1/64/1/5/64  FIFO head entry.
REQ-014: cycle_cnt_o, instr_cnt_o, drop_cnt_o  out  CNT_W each  statistics counters.
REQ-015: fifo_cnt_o  out  clog2(DEPTH)+1  current FIFO occupancy.
REQ-016: halted_o  out  1  drain complete; halt_code_o  out  4  captured error code.

Function
REQ-017: FSM states SHALL be RUN, DRAIN and HALTED; the reset state SHALL be RUN.
REQ-018: In RUN, if error_status_i != 0, the FSM SHALL capture error_status_i into halt_code_o and move to DRAIN on the next edge.
REQ-019: In DRAIN, when the FIFO becomes empty (fifo_cnt_o == 0 with no enqueue pending), the FSM SHALL move to HALTED; DRAIN to HALTED SHALL take at least one cycle.
REQ-020: HALTED SHALL be sticky until rst; halted_o SHALL equal 1 exactly in HALTED.
REQ-021: error_status_i changes in DRAIN or HALTED SHALL be ignored; halt_code_o SHALL hold its captured value.
REQ-022: Retires SHALL be accepted only in RUN, including the cycle in which the error is first seen; in DRAIN and HALTED, retire inputs SHALL be ignored and not counted.
REQ-023: Accepted lanes SHALL enqueue compacted, in ascending lane order, up to RET_W entries per cycle.
REQ-024: Free space for enqueue SHALL be DEPTH minus the pre-dequeue occupancy; a same-cycle dequeue SHALL NOT create enqueue space.
REQ-025: If valid lanes exceed free space, the lowest-numbered valid lanes SHALL fill the space; the remaining lanes SHALL be dropped, and drop_cnt_o SHALL increase by the number dropped.
REQ-026: Dequeue SHALL occur when trace_vld_o && trace_rdy_i, one entry per cycle, in any state.
REQ-027: trace_vld_o SHALL equal (fifo_cnt_o != 0); head fields SHALL be registered FIFO storage, with no combinational path from ret_*_i.
REQ-028: Head fields SHALL be stable while trace_vld_o && !trace_rdy_i.
REQ-029: Read and write pointers SHALL wrap modulo DEPTH; fifo_cnt_o SHALL be updated by (+enqueued - dequeued) each cycle.
REQ-030: cycle_cnt_o SHALL increment by 1 every cycle in RUN and DRAIN, and SHALL freeze in HALTED.
REQ-031: instr_cnt_o SHALL increase by popcount(ret_vld_i) in RUN, dropped lanes included.
REQ-032: All counters SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-033: Enqueue-to-trace_vld_o latency SHALL be 1 cycle when the FIFO is empty.

Reset
REQ-034: On rst: state = RUN, pointers = 0, fifo_cnt_o = 0, trace_vld_o = 0, all counters = 0, halted_o = 0, halt_code_o = 0.
REQ-035: Assertion of rst mid-DRAIN or mid-transfer SHALL discard all FIFO contents immediately (asynchronous reset), with no partial dequeue.
REQ-036: FIFO data storage need not be reset; head data fields SHALL be don't-care while trace_vld_o = 0.

Verification
REQ-037: RET_W=2, DEPTH=4; retire PCs 0x0/0x4 in cycle 1, trace_rdy_i = 1 -> trace shows 0x0 then 0x4 on consecutive cycles; instr_cnt_o = 2; drop_cnt_o = 0.
REQ-038: trace_rdy_i = 0; 3 cycles of 2 valid lanes -> fifo_cnt_o = 4; third cycle drops both lanes; drop_cnt_o = 2; instr_cnt_o = 6; head = first PC, stable.
REQ-039: FIFO at 3 entries, 2 lanes valid, simultaneous dequeue -> lane 0 enqueued, lane 1 dropped; fifo_cnt_o stays 3.
REQ-040: Error 4'h2 with 1 lane valid, 2 entries queued, trace_rdy_i = 1 -> lane accepted; error ignored after capture; 3 dequeues, then halted_o = 1; halt_code_o = 2; cycle_cnt_o frozen; later errors ignored.
REQ-041: CNT_W=4; 20 cycles in RUN -> cycle_cnt_o saturates at 15.
REQ-042: rst pulse between clock edges during DRAIN with 2 entries queued -> immediately fifo_cnt_o = 0, trace_vld_o = 0, state RUN, counters = 0.

Source files
------------

// File: rtl/retire_trace_mon.sv
// ============================================================================
//  Module   : retire_trace_mon
//  Brief    : Retire-stream trace monitor. Compacts up to RET_W retiring
//             instructions per cycle into a trace FIFO, keeps saturating
//             cycle / instruction / drop statistics, and on a core error
//             captures the error code, drains the FIFO and halts.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module retire_trace_mon #(
  parameter int RET_W = 2,
  parameter int DEPTH = 16,
  parameter int CNT_W = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [RET_W-1:0]           ret_vld_i,
  input  logic [RET_W*64-1:0]        ret_pc_i,
  input  logic [RET_W-1:0]           ret_wr_en_i,
  input  logic [RET_W*5-1:0]         ret_dest_i,
  input  logic [RET_W*64-1:0]        ret_data_i,
  input  logic [3:0]                 error_status_i,
  input  logic                       trace_rdy_i,
  output logic                       trace_vld_o,
  output logic [63:0]                trace_pc_o,
  output logic                       trace_wr_o,
  output logic [4:0]                 trace_dest_o,
  output logic [63:0]                trace_data_o,
  output logic [CNT_W-1:0]           cycle_cnt_o,
  output logic [CNT_W-1:0]           instr_cnt_o,
  output logic [CNT_W-1:0]           drop_cnt_o,
  output logic [$clog2(DEPTH):0]     fifo_cnt_o,
  output logic                       halted_o,
  output logic [3:0]                 halt_code_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = PTR_W + 1;
  // Per-cycle lane counts never exceed 4, so 3 bits always suffice.
  localparam int LANE_W = 3;
  localparam logic [OCC_W-1:0] C_DEPTH = OCC_W'(DEPTH);

  typedef enum logic [1:0] {
    S_RUN    = 2'd0,
    S_DRAIN  = 2'd1,
    S_HALTED = 2'd2
  } state_t;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  state_t             state_q;
  logic [3:0]         halt_code_q;
  logic               halted_q;

  logic [PTR_W-1:0]   rd_ptr_q;
  logic [PTR_W-1:0]   wr_ptr_q;
  logic [OCC_W-1:0]   occ_q;

  logic [CNT_W-1:0]   cycle_cnt_q;
  logic [CNT_W-1:0]   instr_cnt_q;
  logic [CNT_W-1:0]   drop_cnt_q;

  // Trace storage; deliberately not reset, head is only meaningful when valid.
  logic [63:0]        mem_pc_q   [DEPTH];
  logic               mem_wr_q   [DEPTH];
  logic [4:0]         mem_dest_q [DEPTH];
  logic [63:0]        mem_data_q [DEPTH];

  // --------------------------------------------------------------------------
  // Next-state / combinational signals
  // --------------------------------------------------------------------------
  logic               w_accept;
  logic               w_deq;
  logic [OCC_W-1:0]   w_free;
  logic [OCC_W-1:0]   w_enq_cnt;
  logic [LANE_W-1:0]  w_ret_cnt;
  logic [LANE_W-1:0]  w_drop_cnt;
  logic [RET_W-1:0]   w_lane_en;
  logic [PTR_W-1:0]   w_lane_addr [RET_W];

  logic [OCC_W-1:0]   occ_d;
  logic [PTR_W-1:0]   rd_ptr_d;
  logic [PTR_W-1:0]   wr_ptr_d;

  // Saturating accumulate: the counter sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                               input logic [LANE_W-1:0] b);
    logic [CNT_W:0] sum;
    sum = {1'b0, a} + (CNT_W+1)'(b);
    if (sum[CNT_W]) begin
      return {CNT_W{1'b1}};
    end
    return sum[CNT_W-1:0];
  endfunction

  // Retires only count in RUN (including the cycle the error is first seen).
  assign w_accept = (state_q == S_RUN);
  // Dequeue is allowed in any state whenever the head is valid and consumed.
  assign w_deq    = (occ_q != '0) && trace_rdy_i;
  // Enqueue space is judged on pre-dequeue occupancy only.
  assign w_free   = C_DEPTH - occ_q;

  // Compact valid lanes in ascending order into free slots; overflow lanes drop.
  always_comb begin
    w_enq_cnt  = '0;
    w_ret_cnt  = '0;
    w_drop_cnt = '0;
    for (int i = 0; i < RET_W; i++) begin
      w_lane_en[i]   = 1'b0;
      w_lane_addr[i] = wr_ptr_q;
      if (w_accept && ret_vld_i[i]) begin
        w_ret_cnt = w_ret_cnt + LANE_W'(1);
        if (w_enq_cnt < w_free) begin
          w_lane_en[i]   = 1'b1;
          w_lane_addr[i] = wr_ptr_q + w_enq_cnt[PTR_W-1:0];
          w_enq_cnt      = w_enq_cnt + OCC_W'(1);
        end else begin
          w_drop_cnt = w_drop_cnt + LANE_W'(1);
        end
      end
    end
  end

  // Pointer and occupancy next-state; pointers wrap naturally at DEPTH.
  always_comb begin
    wr_ptr_d = wr_ptr_q + w_enq_cnt[PTR_W-1:0];
    rd_ptr_d = rd_ptr_q + PTR_W'(w_deq);
    occ_d    = occ_q + w_enq_cnt - OCC_W'(w_deq);
  end

  // --------------------------------------------------------------------------
  // Sequential logic
  // --------------------------------------------------------------------------

  // Control FSM: capture the first error, drain, then halt until reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_RUN;
      halt_code_q <= 4'h0;
      halted_q    <= 1'b0;
    end else begin
      case (state_q)
        S_RUN: begin
          if (error_status_i != 4'h0) begin
            halt_code_q <= error_status_i;
            state_q     <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          // No enqueues happen in DRAIN, so an empty FIFO is final.
          if (occ_q == '0) begin
            state_q  <= S_HALTED;
            halted_q <= 1'b1;
          end
        end
        S_HALTED: begin
          state_q <= S_HALTED;
        end
        default: begin
          state_q <= S_RUN;
        end
      endcase
    end
  end

  // FIFO pointers and occupancy; reset discards all queued entries at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      occ_q    <= occ_d;
    end
  end

  // Saturating statistics counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cycle_cnt_q <= '0;
      instr_cnt_q <= '0;
      drop_cnt_q  <= '0;
    end else begin
      if (state_q != S_HALTED) begin
        cycle_cnt_q <= sat_add(cycle_cnt_q, LANE_W'(1));
      end
      instr_cnt_q <= sat_add(instr_cnt_q, w_ret_cnt);
      drop_cnt_q  <= sat_add(drop_cnt_q, w_drop_cnt);
    end
  end

  // Trace storage writes, one slot per accepted lane.
  always_ff @(posedge clk) begin
    for (int i = 0; i < RET_W; i++) begin
      if (w_lane_en[i]) begin
        mem_pc_q[w_lane_addr[i]]   <= ret_pc_i[i*64 +: 64];
        mem_wr_q[w_lane_addr[i]]   <= ret_wr_en_i[i];
        mem_dest_q[w_lane_addr[i]] <= ret_dest_i[i*5 +: 5];
        mem_data_q[w_lane_addr[i]] <= ret_data_i[i*64 +: 64];
      end
    end
  end

  // --------------------------------------------------------------------------
  // Outputs: head fields come straight from registered storage.
  // --------------------------------------------------------------------------
  assign trace_vld_o  = (occ_q != '0);
  assign trace_pc_o   = mem_pc_q[rd_ptr_q];
  assign trace_wr_o   = mem_wr_q[rd_ptr_q];
  assign trace_dest_o = mem_dest_q[rd_ptr_q];
  assign trace_data_o = mem_data_q[rd_ptr_q];

  assign fifo_cnt_o   = occ_q;
  assign cycle_cnt_o  = cycle_cnt_q;
  assign instr_cnt_o  = instr_cnt_q;
  assign drop_cnt_o   = drop_cnt_q;
  assign halted_o     = halted_q;
  assign halt_code_o  = halt_code_q;

endmodule

`default_nettype wire
